// File: rtl/sys_defs.sv
// ============================================================================
// Module      : sys_defs (package)
// Description : Shared memory-bus definitions: bus commands, the address
//               width, the memory tag type and the request-owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_cmd_e;

    // Tag 0 is reserved to mean "no response / no data".
    typedef logic [3:0] mem_tag_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_tag_table.sv
// ============================================================================
// Module      : mem_tag_table
// Description : Outstanding-load owner table. One valid bit and one owner
//               bit per memory tag. Loads are allocated on acceptance and
//               retired when their data returns; the retire side is looked
//               up combinationally so the arbiter can steer data in the
//               same cycle.
// Ports       : clock, reset          - clock, async active-high reset
//               alloc_en_i/tag/owner  - record an accepted load
//               retire_tag_i          - tag currently returning (0 = none)
//               retire_hit_o/owner_o  - returning tag is outstanding, owner
//               retire_miss_o         - nonzero tag with no valid entry
//               alloc_conflict_o      - alloc onto a still-valid entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_tag_table
    import sys_defs::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     alloc_en_i,
    input  mem_tag_t alloc_tag_i,
    input  owner_e   alloc_owner_i,
    input  mem_tag_t retire_tag_i,
    output logic     retire_hit_o,
    output owner_e   retire_owner_o,
    output logic     retire_miss_o,
    output logic     alloc_conflict_o
);

    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] valid_d;
    logic [NUM_TAGS-1:0] owner_q;
    logic [NUM_TAGS-1:0] owner_d;
    logic                w_retire_req;

    assign w_retire_req   = (retire_tag_i != '0);
    assign retire_hit_o   = w_retire_req &&  valid_q[retire_tag_i];
    assign retire_miss_o  = w_retire_req && !valid_q[retire_tag_i];
    assign retire_owner_o = owner_e'(owner_q[retire_tag_i]);

    // Re-allocating a tag that is retiring in the same cycle is legal.
    assign alloc_conflict_o = alloc_en_i && valid_q[alloc_tag_i] &&
                              !(retire_hit_o && (retire_tag_i == alloc_tag_i));

    // Retire is applied first so a same-cycle allocation of the same tag
    // overrides it and leaves the entry valid with the new owner.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (retire_hit_o) begin
            valid_d[retire_tag_i] = 1'b0;
        end
        if (alloc_en_i && (alloc_tag_i != '0)) begin
            valid_d[alloc_tag_i] = 1'b1;
            owner_d[alloc_tag_i] = alloc_owner_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory port between the icache and the dcache.
//               Dcache has fixed priority; an icache starvation counter
//               grants the icache once after STARVE_LIMIT denied cycles.
//               Accepted loads are tracked per tag so returning data is
//               steered back to the requester that issued it.
// Ports       : clock/reset (async, active-high); Icache2mem_*/Dcache2mem_*
//               requests; mem2proc_* from memory; proc2mem_* to memory;
//               Imem2proc_*/Dmem2proc_* responses to each cache; d_request
//               (dcache owns the bus); tag_error (sticky protocol error).
// Options     : MEM_ARB_CHECK_EN - builds the sticky tag_error checker.
//               Undefined: tag_error is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      Icache2mem_command,
    input  logic [XLEN-1:0] Icache2mem_addr,
    input  logic [1:0]      Dcache2mem_command,
    input  logic [XLEN-1:0] Dcache2mem_addr,
    input  logic [63:0]     Dcache2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [3:0]      Imem2proc_response,
    output logic [63:0]     Imem2proc_data,
    output logic [3:0]      Imem2proc_tag,
    output logic [3:0]      Dmem2proc_response,
    output logic [63:0]     Dmem2proc_data,
    output logic [3:0]      Dmem2proc_tag,
    output logic            d_request,
    output logic            tag_error
);

    localparam int               CNT_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    logic   w_i_req;
    logic   w_d_req;
    logic   w_grant_i;
    logic   w_grant_d;
    logic   w_alloc_en;
    owner_e w_alloc_owner;
    logic   w_retire_hit;
    owner_e w_retire_owner;
    logic   w_retire_miss;
    logic   w_alloc_conflict;
    logic   w_ret_valid;

    assign w_i_req = (Icache2mem_command != BUS_NONE);
    assign w_d_req = (Dcache2mem_command != BUS_NONE);

    // Grants are qualified with reset so every bus output is forced idle
    // while reset is held, without waiting for a clock edge.
    assign w_grant_i = !reset && w_i_req &&
                       ((starve_cnt_q == C_STARVE_MAX) || !w_d_req);
    assign w_grant_d = !reset && w_d_req && !w_grant_i;
    assign d_request = w_grant_d;

    // ------------------------------------------------------------------
    // Request path to memory and acceptance steering
    // ------------------------------------------------------------------
    always_comb begin
        proc2mem_command   = BUS_NONE;
        proc2mem_addr      = '0;
        proc2mem_data      = '0;
        Imem2proc_response = '0;
        Dmem2proc_response = '0;
        if (w_grant_d) begin
            proc2mem_command   = Dcache2mem_command;
            proc2mem_addr      = Dcache2mem_addr;
            proc2mem_data      = Dcache2mem_data;
            Dmem2proc_response = mem2proc_response;
        end else if (w_grant_i) begin
            proc2mem_command   = Icache2mem_command;
            proc2mem_addr      = Icache2mem_addr;
            Imem2proc_response = mem2proc_response;
        end
    end

    // Only accepted loads expect data back; stores are fire-and-forget.
    assign w_alloc_en    = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
    assign w_alloc_owner = w_grant_d ? OWN_D : OWN_I;

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_table (
        .clock            (clock),
        .reset            (reset),
        .alloc_en_i       (w_alloc_en),
        .alloc_tag_i      (mem2proc_response),
        .alloc_owner_i    (w_alloc_owner),
        .retire_tag_i     (mem2proc_tag),
        .retire_hit_o     (w_retire_hit),
        .retire_owner_o   (w_retire_owner),
        .retire_miss_o    (w_retire_miss),
        .alloc_conflict_o (w_alloc_conflict)
    );

    // ------------------------------------------------------------------
    // Data return steering; unknown tags are dropped on both sides
    // ------------------------------------------------------------------
    assign w_ret_valid = !reset && w_retire_hit;

    always_comb begin
        Imem2proc_tag  = '0;
        Imem2proc_data = '0;
        Dmem2proc_tag  = '0;
        Dmem2proc_data = '0;
        if (w_ret_valid) begin
            if (w_retire_owner == OWN_D) begin
                Dmem2proc_tag  = mem2proc_tag;
                Dmem2proc_data = mem2proc_data;
            end else begin
                Imem2proc_tag  = mem2proc_tag;
                Imem2proc_data = mem2proc_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Icache starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = '0;
        if (w_i_req && !w_grant_i) begin
            starve_cnt_d = (starve_cnt_q == C_STARVE_MAX) ? starve_cnt_q
                                                          : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef MEM_ARB_CHECK_EN
    logic tag_error_q;
    logic w_err_event;

    assign w_err_event = !reset &&
                         (w_retire_miss || w_alloc_conflict ||
                          ((mem2proc_response != '0) && !w_grant_i && !w_grant_d));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_error_q <= 1'b0;
        end else if (w_err_event) begin
            tag_error_q <= 1'b1;
        end
    end

    assign tag_error = tag_error_q;
`else
    logic unused_chk;
    assign unused_chk = w_retire_miss ^ w_alloc_conflict;
    assign tag_error  = 1'b0;
`endif

endmodule

`default_nettype wire
